// File: rtl/act_pwl_unit.sv
// act_pwl_unit: two-stage bypass / ReLU / piecewise-linear activation
// Ports: clk, rst_n, in/out lane buses with per-lane valid, cfg write/commit, cfg_busy.
module act_pwl_unit #(
  parameter int BUS_NUM          = 16,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int SLOPE_FRAC       = 4,
  parameter int SEG_NUM          = 4,
  parameter int CFG_ADDR_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] in_fixed_data,
  input  logic [BUS_NUM-1:0]                  in_fixed_data_vld,
  input  logic                                cfg_wr_en,
  input  logic [CFG_ADDR_WIDTH-1:0]           cfg_addr,
  input  logic [FIXED_DATA_WIDTH-1:0]         cfg_wdata,
  input  logic                                cfg_commit,
  output logic                                cfg_busy,
  output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0] out_fixed_data,
  output logic [BUS_NUM-1:0]                  out_fixed_data_vld
);

  localparam int W  = FIXED_DATA_WIDTH;
  localparam int SW = (SEG_NUM > 2) ? $clog2(SEG_NUM) : 1;
  localparam int MAXV = 2**(W-1) - 1;
  localparam int MINV = -(2**(W-1));
  localparam logic signed [2*W:0] RMAX = (2*W+1)'(MAXV);
  localparam logic signed [2*W:0] RMIN = (2*W+1)'(MINV);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  typedef logic signed [W-1:0] dat_t;

  dat_t       sh_bp [SEG_NUM-1];
  dat_t       sh_sl [SEG_NUM];
  dat_t       sh_ic [SEG_NUM];
  logic [1:0] sh_mode;

  dat_t       nx_bp [SEG_NUM-1];
  dat_t       nx_sl [SEG_NUM];
  dat_t       nx_ic [SEG_NUM];
  logic [1:0] nx_mode;

  dat_t       ac_bp [SEG_NUM-1];
  dat_t       ac_sl [SEG_NUM];
  dat_t       ac_ic [SEG_NUM];
  logic [1:0] ac_mode;

  logic [0:0] state;
  logic       swap;

  // Shadow table as it stands after this cycle's write, so a
  // write landing on the swap edge is part of the copy.
  always_comb begin
    nx_bp   = sh_bp;
    nx_sl   = sh_sl;
    nx_ic   = sh_ic;
    nx_mode = sh_mode;
    if (cfg_wr_en) begin
      for (int k = 0; k < SEG_NUM-1; k++)
        if (cfg_addr == CFG_ADDR_WIDTH'(k))
          nx_bp[k] = cfg_wdata;
      for (int s = 0; s < SEG_NUM; s++) begin
        if (cfg_addr == CFG_ADDR_WIDTH'(SEG_NUM-1+s))
          nx_sl[s] = cfg_wdata;
        if (cfg_addr == CFG_ADDR_WIDTH'(2*SEG_NUM-1+s))
          nx_ic[s] = cfg_wdata;
      end
      if (cfg_addr == CFG_ADDR_WIDTH'(3*SEG_NUM-1))
        nx_mode = cfg_wdata[1:0];
    end
  end

  assign swap = (in_fixed_data_vld == '0) &&
                ((state == PENDING) || cfg_commit);
  assign cfg_busy = (state == PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SEG_NUM-1; k++) begin
        sh_bp[k] <= '0;
        ac_bp[k] <= '0;
      end
      for (int s = 0; s < SEG_NUM; s++) begin
        sh_sl[s] <= '0;
        sh_ic[s] <= '0;
        ac_sl[s] <= '0;
        ac_ic[s] <= '0;
      end
      sh_mode <= '0;
      ac_mode <= '0;
      state   <= IDLE;
    end else begin
      sh_bp   <= nx_bp;
      sh_sl   <= nx_sl;
      sh_ic   <= nx_ic;
      sh_mode <= nx_mode;
      if (swap) begin
        ac_bp   <= nx_bp;
        ac_sl   <= nx_sl;
        ac_ic   <= nx_ic;
        ac_mode <= nx_mode;
        state   <= IDLE;
      end else if (cfg_commit) begin
        state <= PENDING;
      end
    end
  end

  dat_t          sel_sl [BUS_NUM];
  dat_t          sel_ic [BUS_NUM];
  dat_t          s1_x   [BUS_NUM];
  dat_t          s1_sl  [BUS_NUM];
  dat_t          s1_ic  [BUS_NUM];
  logic [BUS_NUM-1:0] s1_vld;
  logic [1:0]    s1_mode;

  // Segment index counts breakpoints at or below x, so an
  // unsorted table still gives a defined result.
  always_comb begin
    logic [SW-1:0] seg;
    dat_t          x;
    for (int i = 0; i < BUS_NUM; i++) begin
      x   = in_fixed_data[i*W +: W];
      seg = '0;
      for (int k = 0; k < SEG_NUM-1; k++)
        if (ac_bp[k] <= x)
          seg = seg + SW'(1);
      sel_sl[i] = ac_sl[seg];
      sel_ic[i] = ac_ic[seg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUS_NUM; i++) begin
        s1_x[i]  <= '0;
        s1_sl[i] <= '0;
        s1_ic[i] <= '0;
      end
      s1_vld  <= '0;
      s1_mode <= '0;
    end else begin
      for (int i = 0; i < BUS_NUM; i++) begin
        s1_x[i]  <= in_fixed_data[i*W +: W];
        s1_sl[i] <= sel_sl[i];
        s1_ic[i] <= sel_ic[i];
      end
      s1_vld  <= in_fixed_data_vld;
      s1_mode <= ac_mode;
    end
  end

  dat_t res [BUS_NUM];

  always_comb begin
    logic signed [2*W-1:0] p;
    logic signed [2*W-1:0] q;
    logic signed [2*W:0]   r;
    for (int i = 0; i < BUS_NUM; i++) begin
      p = (2*W)'(s1_x[i]) * (2*W)'(s1_sl[i]);
      q = p >>> SLOPE_FRAC;
      r = (2*W+1)'(q) + (2*W+1)'(s1_ic[i]);
      case (s1_mode)
        2'd1:    res[i] = s1_x[i][W-1] ? '0 : s1_x[i];
        2'd2: begin
          if (r > RMAX)      res[i] = dat_t'(MAXV);
          else if (r < RMIN) res[i] = dat_t'(MINV);
          else               res[i] = r[W-1:0];
        end
        default: res[i] = s1_x[i];
      endcase
      if (!s1_vld[i])
        res[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_fixed_data     <= '0;
      out_fixed_data_vld <= '0;
    end else begin
      for (int i = 0; i < BUS_NUM; i++)
        out_fixed_data[i*W +: W] <= res[i];
      out_fixed_data_vld <= s1_vld;
    end
  end

endmodule

// File: tb/tb_act_pwl_unit.sv
// Bench for act_pwl_unit: reference model + per-cycle compare,
// directed vectors with literal expectations.
module tb_act_pwl_unit;

  localparam int B  = 16;
  localparam int W  = 8;
  localparam int SN = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [B*W-1:0] in_data = '0;
  logic [B-1:0]   in_vld = '0;
  logic           wr_en = 1'b0;
  logic [7:0]     addr = '0;
  logic [7:0]     wdata = '0;
  logic           commit = 1'b0;
  logic           busy;
  logic [B*W-1:0] out_data;
  logic [B-1:0]   out_vld;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  act_pwl_unit #(
    .BUS_NUM(B), .FIXED_DATA_WIDTH(W), .SLOPE_FRAC(4),
    .SEG_NUM(SN), .CFG_ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_fixed_data(in_data), .in_fixed_data_vld(in_vld),
    .cfg_wr_en(wr_en), .cfg_addr(addr), .cfg_wdata(wdata),
    .cfg_commit(commit), .cfg_busy(busy),
    .out_fixed_data(out_data), .out_fixed_data_vld(out_vld)
  );

  always #5 clk = ~clk;

  // Reference model: tables as plain integers.
  int sh_bp [SN-1], sh_sl [SN], sh_ic [SN], sh_mode;
  int ac_bp [SN-1], ac_sl [SN], ac_ic [SN], ac_mode;
  bit m_pend = 0;
  logic [B*W-1:0] p1_d = '0, ex_d = '0;
  logic [B-1:0]   p1_v = '0, ex_v = '0;

  function automatic int fdiv16(int v);
    if (v >= 0) return v / 16;
    return -((-v + 15) / 16);
  endfunction

  function automatic logic [7:0] f(int x);
    int s, y;
    s = 0;
    for (int k = 0; k < SN-1; k++) if (ac_bp[k] <= x) s++;
    if (ac_mode == 1) y = (x < 0) ? 0 : x;
    else if (ac_mode == 2) begin
      y = fdiv16(x * ac_sl[s]) + ac_ic[s];
      if (y > 127) y = 127;
      if (y < -128) y = -128;
    end else y = x;
    return y[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SN-1; k++) begin sh_bp[k] = 0; ac_bp[k] = 0; end
      for (int s = 0; s < SN; s++) begin
        sh_sl[s] = 0; sh_ic[s] = 0; ac_sl[s] = 0; ac_ic[s] = 0;
      end
      sh_mode = 0; ac_mode = 0; m_pend = 0;
      p1_d = '0; p1_v = '0; ex_d = '0; ex_v = '0;
    end else begin
      int x;
      ex_d = p1_d; ex_v = p1_v;
      for (int i = 0; i < B; i++) begin
        x = $signed(in_data[i*W +: W]);
        p1_d[i*W +: W] = in_vld[i] ? f(x) : 8'd0;
      end
      p1_v = in_vld;
      if (wr_en) begin
        if (addr < SN-1) sh_bp[addr] = $signed(wdata);
        else if (addr < 2*SN-1) sh_sl[addr-(SN-1)] = $signed(wdata);
        else if (addr < 3*SN-1) sh_ic[addr-(2*SN-1)] = $signed(wdata);
        else if (addr == 3*SN-1) sh_mode = wdata[1:0];
      end
      if ((m_pend || commit) && in_vld == '0) begin
        ac_bp = sh_bp; ac_sl = sh_sl; ac_ic = sh_ic; ac_mode = sh_mode;
        m_pend = 0;
      end else if (commit) m_pend = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      checks++;
      if (out_data !== ex_d) begin
        errors++;
        $display("FAIL model_data got %h want %h", out_data, ex_d);
      end
      checks++;
      if (out_vld !== ex_v) begin
        errors++;
        $display("FAIL model_vld got %h want %h", out_vld, ex_v);
      end
      checks++;
      if (busy !== m_pend) begin
        errors++;
        $display("FAIL model_busy got %b want %b", busy, m_pend);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  function automatic logic [B*W-1:0] pack4(int a, int b, int c, int d);
    logic [B*W-1:0] r;
    r = '0;
    r[0 +: 8] = a[7:0]; r[8 +: 8] = b[7:0];
    r[16 +: 8] = c[7:0]; r[24 +: 8] = d[7:0];
    return r;
  endfunction

  task automatic step(input logic [B*W-1:0] d, input logic [B-1:0] v,
                      input logic we, input logic [7:0] a,
                      input logic [7:0] wd, input logic cm);
    in_data = d; in_vld = v; wr_en = we; addr = a; wdata = wd; commit = cm;
    @(negedge clk);
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] wd);
    step('0, '0, 1'b1, a, wd, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  logic [7:0] pwl_tab [12];

  initial begin
    logic [B*W-1:0] d;
    pwl_tab = '{8'hA0, 8'hE0, 8'h20, 8'h00, 8'h06, 8'h0C,
                8'h10, 8'h00, 8'h24, 8'h00, 8'h00, 8'h02};
    repeat (2) @(negedge clk);
    chk("rst_data", out_data[31:0], 32'h0);
    chk("rst_vld", 32'(out_vld), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    chk_on = 1;

    step(pack4(-5, 77, 3, 4), 16'h0003, 1'b0, 8'd0, 8'd0, 1'b0);
    idle();
    chk("byp_bus", 32'(out_data), {8'd0, 8'd0, 8'd77, 8'hFB});
    chk("byp_vld", 32'(out_vld), 32'h3);
    chk("byp_busy", 32'(busy), 32'h0);

    step('0, '0, 1'b1, 8'd11, 8'd1, 1'b1);
    chk("relu_commit_busy", 32'(busy), 32'h0);
    step(pack4(-7, 9, 0, 0), 16'h0003, 1'b0, 8'd0, 8'd0, 1'b0);
    idle();
    chk("relu_l0", 32'(lane(0)), 32'h00);
    chk("relu_l1", 32'(lane(1)), 32'h09);

    for (int a = 0; a < 12; a++) wr(8'(a), pwl_tab[a]);
    step('0, '0, 1'b0, 8'd0, 8'd0, 1'b1);
    step(pack4(-100, -64, 20, 100), 16'h000F, 1'b0, 8'd0, 8'd0, 1'b0);
    idle();
    chk("pwl_l0", 32'(lane(0)), 32'h00);
    chk("pwl_l1", 32'(lane(1)), 32'h0C);
    chk("pwl_l2", 32'(lane(2)), 32'h0F);
    chk("pwl_l3", 32'(lane(3)), 32'h64);

    wr(8'd6, 8'h7F);
    wr(8'd3, 8'h7F);
    wr(8'd8, 8'h00);
    step('0, '0, 1'b0, 8'd0, 8'd0, 1'b1);
    step(pack4(100, -100, 0, 0), 16'h0003, 1'b0, 8'd0, 8'd0, 1'b0);
    idle();
    chk("sat_hi", 32'(lane(0)), 32'h7F);
    chk("sat_lo", 32'(lane(1)), 32'h80);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < B; i++) d[i*W +: W] = 8'(k*29 + i*17 + 3);
      d[7:0] = 8'd100;
      d[15:8] = 8'hC0;
      step(d, 16'hFFFF, k == 2, 8'd11, 8'd1, k == 4);
    end
    chk("strm_busy_hi", 32'(busy), 32'h1);
    chk("strm_old_l0", 32'(lane(0)), 32'h7F);
    idle();
    chk("strm_busy_lo", 32'(busy), 32'h0);
    chk("strm_last_old", 32'(lane(0)), 32'h7F);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < B; i++) d[i*W +: W] = 8'(k*53 + i*7 + 11);
      d[7:0] = 8'd100;
      d[15:8] = 8'hC0;
      step(d, 16'hFFFF, 1'b0, 8'd0, 8'd0, 1'b0);
      if (k == 0) chk("strm_bubble_vld", 32'(out_vld), 32'h0);
      if (k == 1) begin
        chk("strm_new_l0", 32'(lane(0)), 32'h64);
        chk("strm_new_l1", 32'(lane(1)), 32'h00);
      end
    end
    idle();
    idle();

    wr(8'd11, 8'd2);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < B; i++) d[i*W +: W] = 8'(k*41 + i*13 + 5);
      step(d, 16'hFFFF, 1'b0, 8'd0, 8'd0, k == 1);
    end
    chk("mid_busy_hi", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(out_data != '0), 32'h0);
    chk("mid_rst_vld", 32'(out_vld), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    in_data = '0; in_vld = '0; commit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(pack4(-7, 50, 0, 0), 16'h0003, 1'b0, 8'd0, 8'd0, 1'b0);
    idle();
    chk("post_rst_byp", 32'(lane(0)), 32'hF9);
    chk("post_rst_vld", 32'(out_vld), 32'h3);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
